// File: rtl/dpll_pkg.sv
// rtl/dpll_pkg.sv - shared DPLL types and default loop constants (also used by the DCO)
package dpll_pkg;

  typedef enum logic [1:0] {
    PH_NONE = 2'd0,
    PH_LEAD = 2'd1,
    PH_LAG  = 2'd2
  } phase_e;

  localparam int DPLL_K_MOD      = 8;
  localparam int DPLL_HOLDOFF    = 20;
  localparam int DPLL_LOCK_EDGES = 64;

  // Classify an accepted data edge against the recovered clock level sampled with it.
  function automatic phase_e phase_of(input logic edge_seen, input logic clk_level);
    if (!edge_seen) return PH_NONE;
    return clk_level ? PH_LEAD : PH_LAG;
  endfunction

endpackage

// File: rtl/dpll_edge_sync.sv
// rtl/dpll_edge_sync.sv - data_in synchronizer, edge detector and holdoff gate
module dpll_edge_sync
  import dpll_pkg::*;
#(
  parameter int HOLDOFF = DPLL_HOLDOFF
) (
  input  logic clk,
  input  logic rst,
  input  logic data_in,
  output logic edge_pulse
);

  // +2 keeps the counter at least one bit wide when HOLDOFF is 0
  localparam int HW = $clog2(HOLDOFF + 2);

  logic          sync1;
  logic          sync2;
  logic          prev;
  logic          primed;
  logic [HW-1:0] holdoff_cnt;
  logic          edge_event;
  logic          accept;

  // primed masks the cycle in which prev is reloaded after reset
  assign edge_event = primed && (sync2 != prev);
  assign accept     = edge_event && (holdoff_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1       <= 1'b0;
      sync2       <= 1'b0;
      prev        <= 1'b0;
      primed      <= 1'b0;
      holdoff_cnt <= '0;
      edge_pulse  <= 1'b0;
    end else begin
      sync1      <= data_in;
      sync2      <= sync1;
      prev       <= sync2;
      primed     <= 1'b1;
      edge_pulse <= accept;
      if (accept) begin
        holdoff_cnt <= HW'(HOLDOFF);
      end else if (holdoff_cnt != '0) begin
        holdoff_cnt <= holdoff_cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/dpll_phase_filter.sv
// rtl/dpll_phase_filter.sv - DPLL phase detector, K-counter loop filter and lock indicator
module dpll_phase_filter
  import dpll_pkg::*;
#(
  parameter int K_MOD      = DPLL_K_MOD,
  parameter int HOLDOFF    = DPLL_HOLDOFF,
  parameter int LOCK_EDGES = DPLL_LOCK_EDGES
) (
  input  logic clk,
  input  logic rst,
  input  logic data_in,
  input  logic clk_Para,
  output logic bothEdge,
  output logic carryPulse,
  output logic subtractionPulse,
  output logic locked
);

  localparam int AW = $clog2(K_MOD) + 1;
  localparam int LW = $clog2(LOCK_EDGES + 1);

  localparam logic signed [AW:0] K_POS = (AW + 1)'(K_MOD);
  localparam logic signed [AW:0] K_NEG = -K_POS;
  localparam logic signed [AW:0] ONE   = (AW + 1)'(1);

  logic                 edge_pulse;
  logic                 clk_para_q;
  phase_e               phase;
  logic signed [AW-1:0] acc;
  logic signed [AW:0]   acc_ext;
  logic signed [AW:0]   acc_sum;
  logic                 hit_pos;
  logic                 hit_neg;
  logic [LW-1:0]        lock_cnt;
  logic [LW-1:0]        lock_next;

  dpll_edge_sync #(
    .HOLDOFF(HOLDOFF)
  ) u_edge_sync (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .edge_pulse(edge_pulse)
  );

  // clk_para_q holds clk_Para from the same edge that registered edge_pulse
  always_comb begin
    phase   = phase_of(edge_pulse, clk_para_q);
    acc_ext = acc;
    acc_sum = acc_ext;
    case (phase)
      PH_LEAD: acc_sum = acc_ext + ONE;
      PH_LAG:  acc_sum = acc_ext - ONE;
      default: acc_sum = acc_ext;
    endcase
    hit_pos = (acc_sum == K_POS);
    hit_neg = (acc_sum == K_NEG);
  end

  always_comb begin
    lock_next = lock_cnt;
    if (hit_pos || hit_neg) begin
      lock_next = '0;
    end else if (edge_pulse && (lock_cnt != LW'(LOCK_EDGES))) begin
      lock_next = lock_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_para_q       <= 1'b0;
      acc              <= '0;
      lock_cnt         <= '0;
      bothEdge         <= 1'b0;
      carryPulse       <= 1'b0;
      subtractionPulse <= 1'b0;
      locked           <= 1'b0;
    end else begin
      clk_para_q       <= clk_Para;
      bothEdge         <= edge_pulse;
      carryPulse       <= hit_pos;
      subtractionPulse <= hit_neg;
      if (edge_pulse) begin
        acc      <= (hit_pos || hit_neg) ? '0 : acc_sum[AW-1:0];
        lock_cnt <= lock_next;
        locked   <= !(hit_pos || hit_neg) && (lock_next == LW'(LOCK_EDGES));
      end
    end
  end

endmodule

// File: tb/tb_dpll_phase_filter.sv
// tb/tb_dpll_phase_filter.sv - scoreboard bench for dpll_phase_filter
module tb_dpll_phase_filter;

  localparam int K = 8;
  localparam int H = 20;
  localparam int L = 64;

  logic clk = 1'b0;
  logic rst;
  logic data_in;
  logic clk_Para;
  logic bothEdge;
  logic carryPulse;
  logic subtractionPulse;
  logic locked;

  always #5 clk = ~clk;

  dpll_phase_filter #(
    .K_MOD(K),
    .HOLDOFF(H),
    .LOCK_EDGES(L)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .data_in         (data_in),
    .clk_Para        (clk_Para),
    .bothEdge        (bothEdge),
    .carryPulse      (carryPulse),
    .subtractionPulse(subtractionPulse),
    .locked          (locked)
  );

  typedef struct packed {
    logic carry;
    logic sub;
    logic lock;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;
  int   m_acc = 0;
  int   m_lock = 0;
  int   edge_seen = 0;
  int   base;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  // Reference loop filter: one call per edge the bench expects to be accepted
  task automatic model_edge(input bit lead);
    exp_t e;
    m_acc += lead ? 1 : -1;
    e.carry = (m_acc == K);
    e.sub   = (m_acc == -K);
    if (e.carry || e.sub) begin
      m_acc  = 0;
      m_lock = 0;
    end else if (m_lock < L) begin
      m_lock++;
    end
    e.lock = (m_lock == L);
    exp_q.push_back(e);
  endtask

  task automatic send_edge(input bit lead, input int gap);
    @(negedge clk);
    clk_Para = lead;
    data_in  = ~data_in;
    model_edge(lead);
    repeat (gap) @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst     = 1'b1;
    data_in = 1'b0;
    @(posedge clk);
    #1;
    check({tag, "_bothEdge"}, bothEdge, 0);
    check({tag, "_carry"}, carryPulse, 0);
    check({tag, "_sub"}, subtractionPulse, 0);
    check({tag, "_locked"}, locked, 0);
    repeat (3) @(negedge clk);
    rst    = 1'b0;
    m_acc  = 0;
    m_lock = 0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bothEdge) begin
        edge_seen++;
        if (exp_q.size() == 0) begin
          check("unexpected_edge", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("carry", carryPulse, mon_e.carry);
          check("sub", subtractionPulse, mon_e.sub);
          check("locked", locked, mon_e.lock);
        end
      end else begin
        check("idle_pulse", {carryPulse, subtractionPulse}, 0);
      end
    end
  end

  initial begin
    rst      = 1'b1;
    data_in  = 1'b0;
    clk_Para = 1'b0;
    repeat (4) @(negedge clk);
    check("init_bothEdge", bothEdge, 0);
    check("init_carry", carryPulse, 0);
    check("init_sub", subtractionPulse, 0);
    check("init_locked", locked, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // latency: first sampled at posedge N, strobe exactly at N+3
    @(negedge clk);
    clk_Para = 1'b1;
    data_in  = 1'b1;
    model_edge(1'b1);
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #1 check("lat_n2", bothEdge, 0);
    @(posedge clk);
    #1 check("lat_n3", bothEdge, 1);
    @(posedge clk);
    #1 check("lat_n4", bothEdge, 0);
    repeat (60) @(negedge clk);

    // accumulator to +5, then reset must clear it
    for (int i = 0; i < 4; i++) send_edge(1'b1, 60);
    do_reset("rst_mid");

    for (int i = 0; i < 8; i++) send_edge(1'b1, 60);
    for (int i = 0; i < 8; i++) send_edge(1'b0, 60);

    do_reset("rst_lock");
    for (int i = 0; i < 100; i++) send_edge((i % 2) == 0, 60);
    for (int i = 0; i < 8; i++) send_edge(1'b1, 60);

    // glitch: second toggle falls inside holdoff
    base = edge_seen;
    @(negedge clk);
    clk_Para = 1'b1;
    data_in  = ~data_in;
    model_edge(1'b1);
    repeat (5) @(negedge clk);
    data_in = ~data_in;
    repeat (25) @(negedge clk);
    check("glitch_one_edge", edge_seen - base, 1);
    data_in = ~data_in;
    model_edge(1'b1);
    repeat (60) @(negedge clk);
    check("glitch_second_edge", edge_seen - base, 2);
    for (int i = 0; i < 6; i++) send_edge(1'b1, 60);

    repeat (10) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
